prior_cov_mac_dim: RTL

//  Parametrised successor of the fixed 2x2 prior-covariance unit: S = A*P*A^T + Q for DIM x DIM matrices.

---
 rtl/prior_cov_mac_dim_pkg.sv | 15 +
 rtl/prior_cov_mac_dim_mac_lane.sv | 60 ++++++
 rtl/prior_cov_mac_dim.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/prior_cov_mac_dim_pkg.sv
// Shared fixed-point format, dimension limit and FSM state encodings for the
// prior-covariance unit S = A*P*A^T + Q.
package prior_cov_mac_dim_pkg;

    localparam int FXP_N             = 16;
    localparam int FXP_FRAC          = 8;
    localparam int PRIOR_COV_MAX_DIM = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PH1  = 2'd1,
        PH2  = 2'd2
    } state_t;

endpackage

// File: rtl/prior_cov_mac_dim_mac_lane.sv
// One MAC lane: full-precision product, wide accumulator and N-bit narrowing.
// Narrowing saturates when PRIOR_COV_SAT_EN is defined, otherwise it wraps.
module prior_cov_mac_dim_mac_lane #(
    parameter int N     = 16,
    parameter int FRAC  = 8,
    parameter int ACC_W = 34
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                first,
    input  logic                add_q,
    input  logic signed [N-1:0] x,
    input  logic signed [N-1:0] y,
    input  logic signed [N-1:0] q,
    output logic signed [N-1:0] result,
    output logic                sat
);

`ifdef PRIOR_COV_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    localparam int HI_W = ACC_W - FRAC;

    logic signed [2*N-1:0]   prod;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] q_term;
    logic signed [ACC_W-1:0] sum;
    logic        [N:0]       narrowed;

    // Takes acc[ACC_W-1:FRAC]; dropping the low bits floors toward -inf.
    // Returns {saturated, value}.
    function automatic logic [N:0] narrow(input logic [HI_W-1:0] v);
        logic [HI_W-N:0] hi;
        logic            fits;
        hi   = v[HI_W-1:N-1];
        fits = (&hi) | ~(|hi);
        if (SAT_EN && !fits)
            return {1'b1, v[HI_W-1], {(N-1){~v[HI_W-1]}}};
        return {1'b0, v[N-1:0]};
    endfunction

    assign prod     = (2*N)'(x) * (2*N)'(y);
    assign q_term   = add_q ? (ACC_W'(q) <<< FRAC) : '0;
    assign sum      = (first ? '0 : acc) + ACC_W'(prod) + q_term;
    assign narrowed = narrow(sum[ACC_W-1:FRAC]);
    assign result   = narrowed[N-1:0];
    assign sat      = narrowed[N];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            acc <= '0;
        else if (en)
            acc <= sum;
    end

endmodule

// File: rtl/prior_cov_mac_dim.sv
// S = A*P*A^T + Q for DIM x DIM fixed-point matrices using DIM MAC lanes:
// PH1 builds T = P*A^T, PH2 builds S = A*T + Q. Option macro: PRIOR_COV_SAT_EN.
module prior_cov_mac_dim
    import prior_cov_mac_dim_pkg::*;
#(
    parameter int N    = FXP_N,
    parameter int FRAC = FXP_FRAC,
    parameter int DIM  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [DIM*DIM*N-1:0]   a_flat,
    input  logic [DIM*DIM*N-1:0]   p_flat,
    input  logic [DIM*DIM*N-1:0]   q_flat,
    output logic                   busy,
    output logic                   done,
    output logic                   ovf,
    output logic [DIM*DIM*N-1:0]   P_PRIOR_FLAT
);

    localparam int ACC_W          = 2*N + $clog2(DIM) + 1;
    localparam int CW             = $clog2(DIM);
    localparam logic [CW-1:0] LAST = CW'(DIM - 1);

    if (DIM < 2 || DIM > PRIOR_COV_MAX_DIM) begin : g_dim_check
        $error("prior_cov_mac_dim: DIM must be in 2..%0d", PRIOR_COV_MAX_DIM);
    end

    state_t state, next_state;

    logic [CW-1:0]       j, k;
    logic signed [N-1:0] a_r [DIM][DIM];
    logic signed [N-1:0] p_r [DIM][DIM];
    logic signed [N-1:0] q_r [DIM][DIM];
    logic signed [N-1:0] t_r [DIM][DIM];
    logic signed [N-1:0] s_r [DIM][DIM];
    logic signed [N-1:0] lane_res [DIM];
    logic [DIM-1:0]      lane_sat;

    logic k_last, j_last, in_run, in_ph2;

    assign k_last = (k == LAST);
    assign j_last = (j == LAST);
    assign in_run = (state == PH1) || (state == PH2);
    assign in_ph2 = (state == PH2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = PH1;
            PH1:     if (k_last && j_last) next_state = PH2;
            PH2:     if (k_last && j_last) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Lane i always owns output row i; j selects the column being built.
    for (genvar i = 0; i < DIM; i++) begin : g_lane
        logic signed [N-1:0] x, y;
        assign x = in_ph2 ? a_r[i][k] : p_r[i][k];
        assign y = in_ph2 ? t_r[k][j] : a_r[j][k];

        prior_cov_mac_dim_mac_lane #(
            .N     (N),
            .FRAC  (FRAC),
            .ACC_W (ACC_W)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .en     (in_run),
            .first  (k == '0),
            .add_q  (in_ph2 && k_last),
            .x      (x),
            .y      (y),
            .q      (q_r[i][j]),
            .result (lane_res[i]),
            .sat    (lane_sat[i])
        );
    end

    for (genvar r = 0; r < DIM; r++) begin : g_out_row
        for (genvar c = 0; c < DIM; c++) begin : g_out_col
            assign P_PRIOR_FLAT[(r*DIM+c)*N +: N] = s_r[r][c];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
            ovf  <= 1'b0;
            j    <= '0;
            k    <= '0;
            for (int r = 0; r < DIM; r++) begin
                for (int c = 0; c < DIM; c++) begin
                    a_r[r][c] <= '0;
                    p_r[r][c] <= '0;
                    q_r[r][c] <= '0;
                    t_r[r][c] <= '0;
                    s_r[r][c] <= '0;
                end
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        ovf  <= 1'b0;
                        j    <= '0;
                        k    <= '0;
                        for (int r = 0; r < DIM; r++) begin
                            for (int c = 0; c < DIM; c++) begin
                                a_r[r][c] <= a_flat[(r*DIM+c)*N +: N];
                                p_r[r][c] <= p_flat[(r*DIM+c)*N +: N];
                                q_r[r][c] <= q_flat[(r*DIM+c)*N +: N];
                            end
                        end
                    end
                end
                PH1, PH2: begin
                    if (k_last) begin
                        k   <= '0;
                        j   <= j_last ? '0 : j + 1'b1;
                        ovf <= ovf | (|lane_sat);
                        for (int i = 0; i < DIM; i++) begin
                            if (in_ph2)
                                s_r[i][j] <= lane_res[i];
                            else
                                t_r[i][j] <= lane_res[i];
                        end
                        if (in_ph2 && j_last) begin
                            done <= 1'b1;
                            busy <= 1'b0;
                        end
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
